key_stream_loader: RTL and testbench

- Receive end of the logic-locking key path. Accepts a serial key frame from the key-provisioning source, checks it against a trailing CRC-8, and presents the verified key in parallel to the locked netlist's key inputs.
- Counts failed load attempts and enters a sticky lockout after a configurable number of failures.
- Sits between the provisioning interface and the locked core; KEY_Q drives the core's key-gate inputs directly.

---
 rtl/key_stream_loader_if.sv | 17 +
 rtl/key_stream_loader.sv | 71 +++++++
 tb/tb_key_stream_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/key_stream_loader_if.sv
// key_stream_loader_if: provisioning-side handshake and verified-key outputs of the key loader
//   start/si/sv : frame request, serial bit and bit-valid from the provisioning source
//   key_q       : verified key for the locked core
//   key_ok/key_err/busy/lockout/fail_cnt : loader status
interface key_stream_loader_if #(parameter int KEY_W = 64);
    logic             start;
    logic             si;
    logic             sv;
    logic [KEY_W-1:0] key_q;
    logic             key_ok;
    logic             key_err;
    logic             busy;
    logic             lockout;
    logic [3:0]       fail_cnt;
    modport master (output start, si, sv, input key_q, key_ok, key_err, busy, lockout, fail_cnt);
    modport slave  (input start, si, sv, output key_q, key_ok, key_err, busy, lockout, fail_cnt);
endinterface

// File: rtl/key_stream_loader.sv
// key_stream_loader: receives a serial key frame, checks its trailing CRC-8 and presents the verified key
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of key_stream_loader_if (start/si/sv in; key_q and status out)
module key_stream_loader #(
    parameter int KEY_W    = 64,
    parameter int MAX_FAIL = 3
) (
    input logic              clk,
    input logic              rst,
    key_stream_loader_if.slave bus
);
    localparam int FRAME_W = KEY_W + 8;
    localparam int CW      = $clog2(FRAME_W + 1);
    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
    state_t             state;
    logic [FRAME_W-1:0] sr;
    logic [CW-1:0]      cnt;
    logic [7:0]         crc;
    logic               fb;
    logic [3:0]         fail_nxt;
    assign fb       = crc[7] ^ bus.si;
    assign fail_nxt = (bus.fail_cnt >= 4'(MAX_FAIL)) ? bus.fail_cnt : bus.fail_cnt + 4'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sr           <= '0;
            cnt          <= '0;
            crc          <= '0;
            bus.key_q    <= '0;
            bus.key_ok   <= 1'b0;
            bus.key_err  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.lockout  <= 1'b0;
            bus.fail_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.start && !bus.lockout) begin
                    state       <= RECV;
                    bus.busy    <= 1'b1;
                    bus.key_ok  <= 1'b0;
                    bus.key_err <= 1'b0;
                    cnt         <= '0;
                    crc         <= '0;
                end
                RECV: if (bus.sv) begin
                    sr  <= {sr[FRAME_W-2:0], bus.si};
                    cnt <= cnt + 1'b1;
                    // CRC covers only the key bits; the last 8 bits are the received CRC itself
                    if (cnt < CW'(KEY_W)) crc <= {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
                    if (cnt == CW'(FRAME_W - 1)) state <= CHECK;
                end
                CHECK: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    if (sr[7:0] == crc) begin
                        bus.key_q    <= sr[FRAME_W-1:8];
                        bus.key_ok   <= 1'b1;
                        bus.fail_cnt <= '0;
                    end else begin
                        // a failed frame relocks the core
                        bus.key_q    <= '0;
                        bus.key_err  <= 1'b1;
                        bus.fail_cnt <= fail_nxt;
                        if (fail_nxt >= 4'(MAX_FAIL)) bus.lockout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_stream_loader.sv
// tb_key_stream_loader: directed and randomized frames checked against a frame-level reference model
module tb_key_stream_loader;
    localparam int KEY_W    = 8;
    localparam int MAX_FAIL = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [KEY_W-1:0] m_key;
    logic             m_ok, m_err, m_lock;
    int               m_fail;
    key_stream_loader_if #(.KEY_W(KEY_W)) bus();
    key_stream_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [7:0] crc8(input logic [KEY_W-1:0] k);
        int c = 0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            c = ((c << 1) & 8'hff) ^ (((c >> 7) ^ int'(k[i])) != 0 ? 8'h07 : 8'h00);
        end
        return 8'(c);
    endfunction
    task automatic model_reset();
        m_key = '0; m_ok = 0; m_err = 0; m_lock = 0; m_fail = 0;
    endtask
    task automatic chk_outs(input string tag);
        chk({tag, "_key"}, 32'(bus.key_q), 32'(m_key));
        chk({tag, "_ok"}, 32'(bus.key_ok), 32'(m_ok));
        chk({tag, "_err"}, 32'(bus.key_err), 32'(m_err));
        chk({tag, "_fail"}, 32'(bus.fail_cnt), 32'(m_fail));
        chk({tag, "_lock"}, 32'(bus.lockout), 32'(m_lock));
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask
    // mode 0: SV every cycle; 1: SV toggling with a 5-cycle gap mid-frame; 2: random gaps
    task automatic run_frame(input string tag, input logic [KEY_W-1:0] key, input logic [7:0] c,
                             input int mode, input bit poke_start, input bit sv_start);
        bit acc = !m_lock;
        logic [KEY_W+7:0] fr = {key, c};
        bus.start = 1; bus.sv = sv_start; bus.si = 1'b1;
        tick();
        bus.start = 0; bus.sv = 0;
        chk({tag, "_busy_start"}, 32'(bus.busy), 32'(acc));
        for (int i = KEY_W + 7; i >= 0; i--) begin
            int gap = (mode == 1) ? ((i == KEY_W) ? 5 : 1) : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (gap) begin
                bus.sv = 0; bus.si = 1'($urandom); bus.start = poke_start;
                tick();
                bus.start = 0;
            end
            bus.sv = 1; bus.si = fr[i];
            tick();
        end
        bus.sv = 0;
        chk({tag, "_busy_check"}, 32'(bus.busy), 32'(acc));
        tick();
        if (acc) begin
            if (c == crc8(key)) begin
                m_key = key; m_ok = 1; m_err = 0; m_fail = 0;
            end else begin
                m_key = '0; m_ok = 0; m_err = 1;
                m_fail = (m_fail < MAX_FAIL) ? m_fail + 1 : m_fail;
                if (m_fail >= MAX_FAIL) m_lock = 1;
            end
        end
        chk_outs(tag);
    endtask
    initial begin
        bus.start = 0; bus.sv = 0; bus.si = 0;
        model_reset();
        tick(); tick();
        rst = 0;
        chk_outs("reset");
        run_frame("good01", 8'h01, 8'h07, 0, 0, 0);
        chk("good01_exact", 32'(bus.key_q), 32'h01);
        run_frame("bad01", 8'h01, 8'h06, 0, 0, 0);
        chk("bad01_exact", 32'(bus.fail_cnt), 1);
        run_frame("stall80", 8'h80, 8'h89, 1, 1, 0);
        chk("stall80_exact", 32'(bus.key_q), 32'h80);
        // reset mid-frame after 5 bits
        bus.start = 1; tick(); bus.start = 0;
        repeat (5) begin bus.sv = 1; bus.si = 1'($urandom); tick(); end
        bus.sv = 0; rst = 1; tick(); tick(); rst = 0;
        model_reset();
        chk_outs("midrst");
        run_frame("after_rst", 8'h5a, crc8(8'h5a), 0, 0, 0);
        repeat (3) run_frame("lock_bad", 8'h33, ~crc8(8'h33), 0, 0, 0);
        chk("lock_set", 32'(bus.lockout), 1);
        chk("lock_cnt", 32'(bus.fail_cnt), 3);
        run_frame("locked_good", 8'h01, 8'h07, 0, 0, 0);
        rst = 1; tick(); rst = 0;
        model_reset();
        chk_outs("unlock");
        run_frame("rec_bad1", 8'hc3, 8'h00 ^ ~crc8(8'hc3), 2, 0, 0);
        run_frame("rec_bad2", 8'h11, crc8(8'h11) ^ 8'h01, 2, 0, 0);
        chk("rec_cnt2", 32'(bus.fail_cnt), 2);
        run_frame("rec_good", 8'h96, crc8(8'h96), 0, 0, 1);
        chk("rec_lock", 32'(bus.lockout), 0);
        for (int n = 0; n < 40; n++) begin
            logic [KEY_W-1:0] k = KEY_W'($urandom);
            logic [7:0] c = ($urandom_range(0, 2) != 0) ? crc8(k) : 8'($urandom);
            run_frame("rand", k, c, 2, 1'($urandom), 1'($urandom));
            if (m_lock && $urandom_range(0, 1) == 1) begin
                run_frame("rand_locked", k, crc8(k), 0, 0, 0);
                rst = 1; tick(); rst = 0;
                model_reset();
                chk_outs("rand_rst");
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
